module_import: RTL and testbench

//   Table-driven pattern sequencer: steps an 8-bit address through a 256 x 32 constant

---
 rtl/module_import_pkg.sv | 20 ++
 rtl/module_import_if.sv | 13 +
 rtl/module_import_rom.sv | 25 ++
 rtl/module_import.sv | 55 +++++
 tb/tb_module_import.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/module_import_pkg.sv
// Shared sizes and the constant pattern table for the module_import sequencer.
package module_import_pkg;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned PRESC_W = 16;

  typedef logic [DEPTH-1:0][WIDTH-1:0] rom_t;

  // Entry i holds i zero-extended to the word width.
  function automatic rom_t rom_init();
    rom_t t;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      t[i] = WIDTH'(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/module_import_if.sv
// Output bundle of the pattern sequencer: table word, address and event pulses.
interface module_import_if;
  import module_import_pkg::*;

  logic [WIDTH-1:0]  out_o;
  logic [ADDR_W-1:0] addr_o;
  logic              step_o;
  logic              wrap_o;

  modport master (output out_o, addr_o, step_o, wrap_o);
  modport slave  (input  out_o, addr_o, step_o, wrap_o);

endinterface

// File: rtl/module_import_rom.sv
// 256 x 32 constant table with a registered read port (one clock of latency).
module module_import_rom
  import module_import_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WIDTH-1:0]  data_o
);

  localparam rom_t Table = rom_init();

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= Table[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/module_import.sv
// Free-running table sequencer: address advances every PARAM+1 clocks, table word
// is presented one clock after its address.
module module_import
  import module_import_pkg::*;
#(
  parameter int unsigned PARAM = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  module_import_if.master bus
);

  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(PARAM);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic [WIDTH-1:0]   rom_data;

  always_comb begin
    step_d  = (presc_q == PrescMax);
    presc_d = step_d ? '0 : presc_q + 1'b1;
    addr_d  = step_d ? addr_q + 1'b1 : addr_q;
    wrap_d  = step_d && (addr_q == '1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc_q <= '0;
      addr_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // Reads the pre-step address, so out_o trails addr_o by exactly one clock.
  module_import_rom u_rom (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  assign bus.out_o  = rom_data;
  assign bus.addr_o = addr_q;
  assign bus.step_o = step_q;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_module_import.sv
// Scoreboard bench for module_import: three instances (PARAM = 0, 3, 1) checked
// every cycle against a closed-form timeline model.
module tb_module_import;
  import module_import_pkg::*;

  typedef struct packed {
    logic [31:0] out;
    logic [7:0]  addr;
    logic        step;
    logic        wrap;
  } exp_t;

  logic clk;
  logic rst0, rst3, rst1;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  module_import_if ifs0 ();
  module_import_if ifs3 ();
  module_import_if ifs1 ();

  module_import #(.PARAM(0)) u_dut0 (.clk_i(clk), .rst_i(rst0), .bus(ifs0));
  module_import #(.PARAM(3)) u_dut3 (.clk_i(clk), .rst_i(rst3), .bus(ifs3));
  module_import #(.PARAM(1)) u_dut1 (.clk_i(clk), .rst_i(rst1), .bus(ifs1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after k edges since reset release, divider n.
  function automatic exp_t model(int k, int n);
    exp_t e;
    e.addr = 8'((k / (n + 1)) % 256);
    e.out  = (k == 0) ? 32'd0 : 32'(((k - 1) / (n + 1)) % 256);
    e.step = (k > 0) && (k % (n + 1) == 0);
    e.wrap = e.step && (e.addr == 8'd0);
    return e;
  endfunction

  function automatic exp_t got0();
    return {ifs0.out_o, ifs0.addr_o, ifs0.step_o, ifs0.wrap_o};
  endfunction

  function automatic exp_t got3();
    return {ifs3.out_o, ifs3.addr_o, ifs3.step_o, ifs3.wrap_o};
  endfunction

  function automatic exp_t got1();
    return {ifs1.out_o, ifs1.addr_o, ifs1.step_o, ifs1.wrap_o};
  endfunction

  int k0, k3, k1;

  task automatic test_reset();
    exp_t e, g;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      sb.push_back(model(0, 0));
      @(negedge clk);
      e = sb.pop_front();
      g = got0();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d: got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_run10();
    exp_t e, g;
    rst0 = 1'b1;
    k0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      k0++;
      sb.push_back(model(k0, 0));
      @(negedge clk);
      e = sb.pop_front();
      g = got0();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL run10 edge=%0d: got %h want %h", k0, g, e);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e, g;
    int wraps = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      k0++;
      sb.push_back(model(k0, 0));
      @(negedge clk);
      e = sb.pop_front();
      g = got0();
      wraps += int'(ifs0.wrap_o === 1'b1);
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL wrap0 edge=%0d: got %h want %h", k0, g, e);
      end
    end
    vectors++;
    if (wraps != 1) begin
      miscompares++;
      $display("FAIL wrap0_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_async_reset();
    exp_t e, g;
    while (k0 < 384) begin
      @(posedge clk);
      k0++;
      sb.push_back(model(k0, 0));
      @(negedge clk);
      e = sb.pop_front();
      g = got0();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL pre_reset edge=%0d: got %h want %h", k0, g, e);
      end
    end
    @(posedge clk);
    #2 rst0 = 1'b0;
    #1;
    sb.push_back(model(0, 0));
    e = sb.pop_front();
    g = got0();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got %h want %h", g, e);
    end
    @(negedge clk);
    rst0 = 1'b1;
    k0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      k0++;
      sb.push_back(model(k0, 0));
      @(negedge clk);
      e = sb.pop_front();
      g = got0();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL restart edge=%0d: got %h want %h", k0, g, e);
      end
    end
  endtask

  task automatic test_presc3();
    exp_t e, g;
    rst3 = 1'b1;
    k3 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      k3++;
      sb.push_back(model(k3, 3));
      @(negedge clk);
      e = sb.pop_front();
      g = got3();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL presc3 edge=%0d: got %h want %h", k3, g, e);
      end
    end
    vectors++;
    if (ifs3.addr_o !== 8'd3) begin
      miscompares++;
      $display("FAIL presc3_final_addr: got %0d want 3", ifs3.addr_o);
    end
  endtask

  task automatic test_presc1();
    exp_t e, g;
    int wraps = 0;
    rst1 = 1'b1;
    k1 = 0;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk);
      k1++;
      sb.push_back(model(k1, 1));
      @(negedge clk);
      e = sb.pop_front();
      g = got1();
      wraps += int'(ifs1.wrap_o === 1'b1);
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL presc1 edge=%0d: got %h want %h", k1, g, e);
      end
    end
    vectors++;
    if (wraps != 2) begin
      miscompares++;
      $display("FAIL presc1_wrap_count: got %0d want 2", wraps);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst0 = 1'b0;
    rst3 = 1'b0;
    rst1 = 1'b0;
    #1;
    test_reset();
    test_run10();
    test_wrap();
    test_async_reset();
    test_presc3();
    test_presc1();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
